// File: rtl/nn_vote_sequencer.sv
// Sequencer for the QuantCNN wrapper: launches one inference per frame, times out hung runs,
// and publishes a majority vote over the last DEPTH accepted predictions.
module nn_vote_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_W     = 4,
    parameter int DEPTH       = 8,
    parameter int THRESH      = 5,
    parameter int TO_W        = 24,
    parameter int TIMEOUT     = 5000000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               cfg_resize,
    input  logic               cfg_bin,
    input  logic               frame_tick,
    input  logic [31:0]        nn_data,
    input  logic               nn_en,
    output logic [31:0]        nn_arg,
    output logic [CLASS_W-1:0] class_out,
    output logic [CLASS_W:0]   class_votes,
    output logic               class_valid,
    output logic               class_upd,
    output logic               busy,
    output logic [7:0]         err_timeout,
    output logic [7:0]         err_reject,
    output logic [2:0]         dbg_state
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;
    localparam logic [CLASS_W:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_CLR  = 3'd2,
        S_WAIT = 3'd3,
        S_VOTE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]         arg_q, arg_d;
    logic [CLASS_W-1:0] pred_q, pred_d;
    logic               rej_q, rej_d;
    logic [CLASS_W-1:0] hist_q [DEPTH];
    logic [CLASS_W-1:0] hist_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CLASS_W:0]   cnt_q [NUM_CLASSES];
    logic [CLASS_W:0]   cnt_d [NUM_CLASSES];
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic [CLASS_W:0]   votes_q, votes_d;
    logic               valid_q, valid_d;
    logic               upd_q, upd_d;
    logic [7:0]         err_to_q, err_to_d;
    logic [7:0]         err_rej_q, err_rej_d;

    logic               push;
    logic               full;
    logic [CLASS_W-1:0] oldest;
    logic [CLASS_W-1:0] best_idx;
    logic [CLASS_W:0]   best_cnt;

    // Run control: nn_en wins over an expiring timeout in the same WAIT cycle.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        pred_d    = pred_q;
        rej_d     = rej_q;
        err_to_d  = err_to_q;
        err_rej_d = err_rej_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: if (frame_tick && enable) state_d = S_ARM;
            S_ARM:  state_d = S_CLR;
            S_CLR: begin
                state_d  = S_WAIT;
                to_cnt_d = '0;
            end
            S_WAIT: begin
                if (nn_en) begin
                    state_d = S_VOTE;
                    pred_d  = nn_data[CLASS_W-1:0];
                    rej_d   = (nn_data >= 32'(NUM_CLASSES));
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    if (err_to_q != 8'hFF) err_to_d = err_to_q + 8'd1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_VOTE: begin
                state_d = S_IDLE;
                if (rej_q) begin
                    if (err_rej_q != 8'hFF) err_rej_d = err_rej_q + 8'd1;
                end else begin
                    push = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // History ring: when full, the write pointer addresses the oldest entry.
    always_comb begin
        full     = (fill_q == FILL_W'(DEPTH));
        oldest   = hist_q[wr_ptr_q];
        hist_d   = hist_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            hist_d[wr_ptr_q] = pred_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (!full) fill_d = fill_q + FILL_W'(1);
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push && pred_q == CLASS_W'(i)) cnt_d[i] = cnt_d[i] + CNT_ONE;
            if (push && full && oldest == CLASS_W'(i)) cnt_d[i] = cnt_d[i] - CNT_ONE;
        end
    end

    // Argmax over the post-push counts; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_cnt = cnt_d[0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (cnt_d[i] > best_cnt) begin
                best_idx = CLASS_W'(i);
                best_cnt = cnt_d[i];
            end
        end
        cls_d   = cls_q;
        votes_d = votes_q;
        valid_d = valid_q;
        upd_d   = push;
        if (push) begin
            cls_d   = best_idx;
            votes_d = best_cnt;
            valid_d = (best_cnt >= (CLASS_W+1)'(THRESH));
        end
        arg_d = {cfg_bin, cfg_resize, (state_d == S_ARM), (enable || (state_d != S_IDLE))};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            arg_q     <= '0;
            pred_q    <= '0;
            rej_q     <= 1'b0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            cls_q     <= '0;
            votes_q   <= '0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            err_to_q  <= '0;
            err_rej_q <= '0;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            arg_q     <= arg_d;
            pred_q    <= pred_d;
            rej_q     <= rej_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            cls_q     <= cls_d;
            votes_q   <= votes_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            err_to_q  <= err_to_d;
            err_rej_q <= err_rej_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
        end
    end

    assign nn_arg      = {28'b0, arg_q};
    assign class_out   = cls_q;
    assign class_votes = votes_q;
    assign class_valid = valid_q;
    assign class_upd   = upd_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_to_q;
    assign err_reject  = err_rej_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_nn_vote_sequencer.sv
// Self-checking bench for nn_vote_sequencer: a reference vote model fills an expected queue
// on every accepted prediction; a negedge monitor pops it on each class_upd.
module tb_nn_vote_sequencer;

    localparam int NC     = 10;
    localparam int CW     = 4;
    localparam int DEPTH  = 8;
    localparam int THRESH = 5;
    localparam int TO     = 50;

    logic          CLK;
    logic          RST;
    logic          enable;
    logic          cfg_resize;
    logic          cfg_bin;
    logic          frame_tick;
    logic [31:0]   nn_data;
    logic          nn_en;
    logic [31:0]   nn_arg;
    logic [CW-1:0] class_out;
    logic [CW:0]   class_votes;
    logic          class_valid;
    logic          class_upd;
    logic          busy;
    logic [7:0]    err_timeout;
    logic [7:0]    err_reject;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_e;
    int hist_m[$];
    int exp_err_to  = 0;
    int exp_err_rej = 0;

    nn_vote_sequencer #(
        .NUM_CLASSES(NC), .CLASS_W(CW), .DEPTH(DEPTH), .THRESH(THRESH),
        .TO_W(24), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .cfg_resize(cfg_resize), .cfg_bin(cfg_bin),
        .frame_tick(frame_tick), .nn_data(nn_data), .nn_en(nn_en), .nn_arg(nn_arg),
        .class_out(class_out), .class_votes(class_votes), .class_valid(class_valid),
        .class_upd(class_upd), .busy(busy), .err_timeout(err_timeout), .err_reject(err_reject),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // reference vote: sliding window, lowest index wins ties
    function automatic logic [9:0] model_push(input int p);
        int cnt[NC];
        int best;
        int best_cnt;
        logic [3:0] bi;
        logic [4:0] bc;
        hist_m.push_back(p);
        if (hist_m.size() > DEPTH) void'(hist_m.pop_front());
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        foreach (hist_m[k]) cnt[hist_m[k]]++;
        best = 0;
        best_cnt = cnt[0];
        for (int i = 1; i < NC; i++) begin
            if (cnt[i] > best_cnt) begin
                best = i;
                best_cnt = cnt[i];
            end
        end
        bi = 4'(best);
        bc = 5'(best_cnt);
        return {bi, bc, (best_cnt >= THRESH)};
    endfunction

    // scoreboard monitor
    always @(negedge CLK) begin
        if (class_upd) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_upd", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check_val("class_out", 32'(class_out), 32'(exp_e[9:6]));
                check_val("class_votes", 32'(class_votes), 32'(exp_e[5:1]));
                check_val("class_valid", 32'(class_valid), 32'(exp_e[0]));
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Leaves the bench in WAIT cycle 0.
    task automatic start_run();
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        check_val("arm_arg", nn_arg, {28'b0, cfg_bin, cfg_resize, 2'b11});
        tick(1);
        check_val("clr_arg", nn_arg, {28'b0, cfg_bin, cfg_resize, 2'b01});
        tick(1);
    endtask

    task automatic finish_run(input int wait_cyc, input int data);
        tick(wait_cyc);
        nn_en   = 1'b1;
        nn_data = 32'(data);
        if (data < NC) exp_q.push_back(model_push(data));
        else if (exp_err_rej < 255) exp_err_rej++;
        tick(1);
        nn_en = 1'b0;
        check_val("vote_no_upd", 32'(class_upd), 32'd0);
        tick(1);
        check_val("upd_latency", 32'(class_upd), (data < NC) ? 32'd1 : 32'd0);
        tick(2);
        check_val("err_reject", 32'(err_reject), 32'(exp_err_rej));
        check_val("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic run(input int wait_cyc, input int data);
        start_run();
        finish_run(wait_cyc, data);
    endtask

    initial begin
        RST = 1'b1; enable = 1'b0; cfg_resize = 1'b0; cfg_bin = 1'b0;
        frame_tick = 1'b0; nn_data = '0; nn_en = 1'b0;
        tick(3);
        check_val("rst_nn_arg", nn_arg, 32'd0);
        check_val("rst_class_out", 32'(class_out), 32'd0);
        check_val("rst_votes", 32'(class_votes), 32'd0);
        check_val("rst_valid", 32'(class_valid), 32'd0);
        check_val("rst_upd", 32'(class_upd), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err_to", 32'(err_timeout), 32'd0);
        check_val("rst_err_rej", 32'(err_reject), 32'd0);
        RST = 1'b0;
        enable = 1'b1;
        cfg_resize = 1'b1;
        tick(2);
        check_val("idle_arg", nn_arg, 32'h5);

        // first run, then a run of 7s and a run of 2s
        run(20, 3);
        for (int i = 0; i < 5; i++) run($urandom_range(1, 40), 7);
        for (int i = 0; i < 8; i++) run($urandom_range(1, 40), 2);

        // tie between 1 and 4
        for (int i = 0; i < 4; i++) run($urandom_range(0, 30), 1);
        for (int i = 0; i < 4; i++) run($urandom_range(0, 30), 4);

        // timeout, then an answer on the last legal WAIT cycle
        start_run();
        tick(TO - 1);
        check_val("to_still_busy", 32'(busy), 32'd1);
        tick(1);
        exp_err_to++;
        check_val("to_idle", 32'(busy), 32'd0);
        check_val("err_timeout", 32'(err_timeout), 32'(exp_err_to));
        run(10, 4);
        run(TO - 1, 4);
        check_val("err_timeout_hold", 32'(err_timeout), 32'(exp_err_to));

        // reject, stray nn_en, dropped frame_tick
        run(5, 12);
        nn_en = 1'b1;
        nn_data = 32'd5;
        tick(1);
        nn_en = 1'b0;
        tick(3);
        check_val("stray_busy", 32'(busy), 32'd0);
        check_val("stray_err_rej", 32'(err_reject), 32'(exp_err_rej));
        start_run();
        tick(5);
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        finish_run(5, 4);

        // enable dropped mid-run: run completes, no new run starts
        start_run();
        enable = 1'b0;
        finish_run(10, 6);
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        tick(1);
        check_val("disabled_busy", 32'(busy), 32'd0);
        check_val("disabled_arg", nn_arg, 32'h4);
        enable = 1'b1;
        tick(1);

        // random runs
        for (int i = 0; i < 12; i++) begin
            cfg_bin = 1'($urandom_range(0, 1));
            tick(1);
            run($urandom_range(0, TO - 1), $urandom_range(0, NC + 1));
        end

        // reset in WAIT abandons the run; late nn_en is ignored
        start_run();
        tick(3);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        hist_m.delete();
        exp_err_to = 0;
        exp_err_rej = 0;
        nn_en = 1'b1;
        nn_data = 32'd3;
        tick(1);
        nn_en = 1'b0;
        tick(3);
        check_val("rstwait_busy", 32'(busy), 32'd0);
        check_val("rstwait_class", 32'(class_out), 32'd0);
        check_val("rstwait_votes", 32'(class_votes), 32'd0);
        check_val("rstwait_err_to", 32'(err_timeout), 32'd0);
        run(8, 9);

        tick(2);
        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
